// File: rtl/adc_multilane_capture.sv
// Capture controller for a simultaneous-sampling multi-lane serial ADC: drives CNV/SCK,
// deserialises every lane in the clk domain and emits each frame as one wide valid/ready word.
module adc_multilane_capture #(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = 16,
    parameter int TCNVH_CYC = 4,
    parameter int TCONV_CYC = 25,
    parameter int SCK_HALF  = 1,
    parameter int FRAME_CYC = 64,
    parameter int CNT_W     = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sample_en,
    input  logic                        trigger,
    input  logic                        overrun_clr,
    output logic                        cnv,
    output logic                        sck,
    input  logic [NUM_LANES-1:0]        sdo,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [NUM_LANES*DATA_W-1:0] m_data,
    output logic                        overrun,
    output logic                        busy
);

    typedef enum logic [2:0] {IDLE, CNVH, CONV, SHIFT, WAIT} state_t;

    localparam logic [CNT_W-1:0] CNVH_LAST  = CNT_W'(TCNVH_CYC - 1);
    localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(TCONV_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(SCK_HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'((FRAME_CYC > 0) ? FRAME_CYC - 1 : 0);

    // state is kept as a named signal so checkers can bind to it directly
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] fcnt, fcnt_n;
    logic [CNT_W-1:0] hcnt, hcnt_n;
    logic [CNT_W-1:0] bcnt, bcnt_n;
    logic             phase, phase_n;  // 0: sck high half, 1: sck low half
    logic             sample_bit;
    logic             frame_done;
    logic             load;
    logic             drop;
    logic [DATA_W-1:0] sr [NUM_LANES];

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        hcnt_n     = hcnt;
        bcnt_n     = bcnt;
        phase_n    = phase;
        sample_bit = 1'b0;
        fcnt_n     = (fcnt == '1) ? fcnt : fcnt + 1'b1;

        case (state)
            IDLE: begin
                if (sample_en || trigger) begin
                    state_n = CNVH;
                    cnt_n   = '0;
                end
            end
            CNVH: begin
                if (cnt == CNVH_LAST) begin
                    state_n = CONV;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            CONV: begin
                if (cnt == CONV_LAST) begin
                    state_n = SHIFT;
                    hcnt_n  = '0;
                    bcnt_n  = '0;
                    phase_n = 1'b0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            SHIFT: begin
                if (hcnt == HALF_LAST) begin
                    hcnt_n  = '0;
                    phase_n = ~phase;
                    if (!phase) begin
                        sample_bit = 1'b1;
                    end else if (bcnt == BIT_LAST) begin
                        state_n = WAIT;
                    end else begin
                        bcnt_n = bcnt + 1'b1;
                    end
                end else begin
                    hcnt_n = hcnt + 1'b1;
                end
            end
            WAIT: begin
                // >= also covers a FRAME_CYC shorter than the conversion itself
                if (fcnt >= FRAME_LAST) begin
                    state_n = sample_en ? CNVH : IDLE;
                    cnt_n   = '0;
                end
            end
            default: state_n = IDLE;
        endcase

        if (state_n == CNVH && state != CNVH) begin
            fcnt_n = '0;
        end
    end

    // Handshake: a word transfers on any cycle with m_valid && m_ready; while m_valid is
    // high m_data is frozen. A new frame only loads when the slot is empty or being accepted
    // in that same cycle; otherwise the frame is discarded and overrun latches.
    assign frame_done = (state == SHIFT) && (state_n == WAIT);
    assign load       = frame_done && (!m_valid || m_ready);
    assign drop       = frame_done && m_valid && !m_ready;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            fcnt    <= '0;
            hcnt    <= '0;
            bcnt    <= '0;
            phase   <= 1'b0;
            cnv     <= 1'b0;
            sck     <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                sr[i] <= '0;
            end
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            fcnt  <= fcnt_n;
            hcnt  <= hcnt_n;
            bcnt  <= bcnt_n;
            phase <= phase_n;
            cnv   <= (state_n == CNVH);
            sck   <= (state_n == SHIFT) && !phase_n;

            if (sample_bit) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    sr[i] <= {sr[i][DATA_W-2:0], sdo[i]};
                end
            end

            if (load) begin
                m_valid <= 1'b1;
                for (int i = 0; i < NUM_LANES; i++) begin
                    m_data[i*DATA_W +: DATA_W] <= sr[i];
                end
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end

            if (drop) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_multilane_capture.sv
// Directed bench for adc_multilane_capture: default-parameter instance plus a slow-SCK,
// short-frame instance, each fed by a simple per-lane serial ADC model.
module tb_adc_multilane_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_en, trigger, overrun_clr, m_ready;
    logic [3:0]  sdo = '0;
    logic        cnv, sck, m_valid, overrun, busy;
    logic [63:0] m_data;

    logic        sample_en2, m_ready2;
    logic        trigger2 = 1'b0;
    logic        overrun_clr2 = 1'b0;
    logic [3:0]  sdo2 = '0;
    logic        cnv2, sck2, m_valid2, overrun2, busy2;
    logic [63:0] m_data2;

    adc_multilane_capture dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .trigger(trigger),
        .overrun_clr(overrun_clr), .cnv(cnv), .sck(sck), .sdo(sdo),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .overrun(overrun), .busy(busy)
    );

    adc_multilane_capture #(.SCK_HALF(3), .FRAME_CYC(10)) dut2 (
        .clk(clk), .rst(rst), .sample_en(sample_en2), .trigger(trigger2),
        .overrun_clr(overrun_clr2), .cnv(cnv2), .sck(sck2), .sdo(sdo2),
        .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2),
        .overrun(overrun2), .busy(busy2)
    );

    always #5 clk = ~clk;

    // ADC model: words latched on CNV rise, next bit (MSB first) presented on each SCK rise
    logic [15:0] pat [4];
    logic [15:0] lat [4];
    int          bi;
    logic [15:0] pat2 [4];
    logic [15:0] lat2 [4];
    int          bi2;

    always @(posedge cnv) begin
        for (int i = 0; i < 4; i++) lat[i] = pat[i];
        bi = 0;
    end

    always @(posedge sck) begin
        if (bi < 16) begin
            for (int i = 0; i < 4; i++) sdo[i] = lat[i][15-bi];
            bi++;
        end
    end

    always @(posedge cnv2) begin
        for (int i = 0; i < 4; i++) lat2[i] = pat2[i];
        bi2 = 0;
    end

    always @(posedge sck2) begin
        if (bi2 < 16) begin
            for (int i = 0; i < 4; i++) sdo2[i] = lat2[i][15-bi2];
            bi2++;
        end
    end

    logic        sel;
    logic        mon_cnv, mon_sck, mon_valid, mon_busy;
    logic [63:0] mon_data;

    always_comb begin
        mon_cnv   = sel ? cnv2 : cnv;
        mon_sck   = sel ? sck2 : sck;
        mon_valid = sel ? m_valid2 : m_valid;
        mon_busy  = sel ? busy2 : busy;
        mon_data  = sel ? m_data2 : m_data;
    end

    typedef struct {
        logic [15:0] p0, p1, p2, p3;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        int          cnv_hi, sck_pulses, sck_hi, valid_at, period, n_valid, last_busy;
        logic [63:0] data;
    } meas_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_pat(input logic [15:0] a, b, c, d);
        pat[0] = a; pat[1] = b; pat[2] = c; pat[3] = d;
    endtask

    task automatic wait_cnv(input int budget);
        int n = 0;
        while (!mon_cnv && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!mon_cnv) begin
            n_tests++;
            n_fail++;
            $display("FAIL cnv_timeout: got 0 expected 1 within %0d cycles", budget);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (mon_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (mon_busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: got busy=1 expected 0 within %0d cycles", budget);
        end
    endtask

    // Called on the first sample with cnv high (k=0); stops at the next cnv rise or the budget.
    task automatic measure(input int budget, input int drop_at, input int trig_at, output meas_t r);
        logic pc, ps;
        r.cnv_hi = 0; r.sck_pulses = 0; r.sck_hi = 0; r.valid_at = -1;
        r.period = -1; r.n_valid = 0; r.last_busy = -1; r.data = '0;
        pc = 1'b1;
        ps = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (k > 0 && mon_cnv && !pc) begin
                r.period = k;
                break;
            end
            if (mon_cnv) r.cnv_hi++;
            if (mon_sck) begin
                r.sck_hi++;
                if (!ps) r.sck_pulses++;
            end
            if (mon_valid) begin
                r.n_valid++;
                if (r.valid_at < 0) begin
                    r.valid_at = k;
                    r.data = mon_data;
                end
            end
            if (mon_busy) r.last_busy = k;
            pc = mon_cnv;
            ps = mon_sck;
            if (k == drop_at) sample_en = 1'b0;
            if (k == trig_at) trigger = 1'b1;
            else if (k == trig_at + 1) trigger = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vecs [3];
        meas_t r;
        int    nv;

        vecs[0] = '{p0:16'h1234, p1:16'hA5A5, p2:16'h0001, p3:16'hFFFF, exp:64'hFFFF_0001_A5A5_1234};
        vecs[1] = '{p0:16'h0000, p1:16'hFFFF, p2:16'h8000, p3:16'h0001, exp:64'h0001_8000_FFFF_0000};
        vecs[2] = '{p0:16'hDEAD, p1:16'hBEEF, p2:16'h5555, p3:16'hAAAA, exp:64'hAAAA_5555_BEEF_DEAD};

        sel = 1'b0;
        rst = 1'b1;
        sample_en = 1'b0; trigger = 1'b0; overrun_clr = 1'b0; m_ready = 1'b0;
        sample_en2 = 1'b0; m_ready2 = 1'b0;
        set_pat(16'h0, 16'h0, 16'h0, 16'h0);
        pat2[0] = 16'hC001; pat2[1] = 16'h0FF0; pat2[2] = 16'h1357; pat2[3] = 16'h2468;

        // reset state
        step(3);
        rst = 1'b0;
        step(1);
        check("rst_cnv", cnv, 0);
        check("rst_sck", sck, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);

        // continuous frames from the vector table
        m_ready = 1'b1;
        set_pat(vecs[0].p0, vecs[0].p1, vecs[0].p2, vecs[0].p3);
        sample_en = 1'b1;
        wait_cnv(10);
        for (int v = 0; v < 3; v++) begin
            nv = (v < 2) ? v + 1 : 2;
            set_pat(vecs[nv].p0, vecs[nv].p1, vecs[nv].p2, vecs[nv].p3);
            measure(200, -1, -1, r);
            check($sformatf("v%0d_cnv_hi", v), r.cnv_hi, 4);
            check($sformatf("v%0d_sck_pulses", v), r.sck_pulses, 16);
            check($sformatf("v%0d_sck_hi", v), r.sck_hi, 16);
            check($sformatf("v%0d_valid_at", v), r.valid_at, 61);
            check($sformatf("v%0d_period", v), r.period, 64);
            check($sformatf("v%0d_data", v), r.data, vecs[v].exp);
        end
        sample_en = 1'b0;
        wait_idle(200);

        // single-shot trigger, with an ignored second trigger mid-frame
        set_pat(16'h0F0F, 16'h3C3C, 16'h7E7E, 16'h8181);
        step(1);
        trigger = 1'b1;
        step(1);
        trigger = 1'b0;
        measure(150, -1, 30, r);
        check("trig_cnv_hi", r.cnv_hi, 4);
        check("trig_second_cnv", r.period, -1);
        check("trig_n_valid", r.n_valid, 1);
        check("trig_last_busy", r.last_busy, 63);
        check("trig_data", r.data, 64'h8181_7E7E_3C3C_0F0F);

        // back-pressure: held word, overrun, clear racing a drop, accept racing a load
        m_ready = 1'b0;
        set_pat(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        step(1);
        sample_en = 1'b1;
        wait_cnv(10);
        set_pat(16'h5555, 16'h6666, 16'h7777, 16'h8888);
        step(61);
        check("ovr_f1_valid", m_valid, 1);
        check("ovr_f1_data", m_data, 64'h4444_3333_2222_1111);
        check("ovr_f1_flag", overrun, 0);
        wait_cnv(10);
        set_pat(16'h9999, 16'hAAAA, 16'hBBBB, 16'hCCCC);
        step(61);
        check("ovr_f2_flag", overrun, 1);
        check("ovr_f2_data", m_data, 64'h4444_3333_2222_1111);
        check("ovr_f2_valid", m_valid, 1);
        wait_cnv(10);
        set_pat(16'h0102, 16'h0304, 16'h0506, 16'h0708);
        step(60);
        overrun_clr = 1'b1;
        step(1);
        overrun_clr = 1'b0;
        check("ovr_clr_vs_drop", overrun, 1);
        check("ovr_f3_data", m_data, 64'h4444_3333_2222_1111);
        step(1);
        overrun_clr = 1'b1;
        step(1);
        overrun_clr = 1'b0;
        check("ovr_cleared", overrun, 0);
        check("ovr_held_data", m_data, 64'h4444_3333_2222_1111);
        check("ovr_held_valid", m_valid, 1);
        wait_cnv(10);
        sample_en = 1'b0;
        step(60);
        m_ready = 1'b1;
        step(1);
        check("acc_load_valid", m_valid, 1);
        check("acc_load_data", m_data, 64'h0708_0506_0304_0102);
        check("acc_load_overrun", overrun, 0);
        step(1);
        check("acc_drained", m_valid, 0);
        wait_idle(100);

        // slow SCK, frame period longer than FRAME_CYC
        sel = 1'b1;
        m_ready2 = 1'b1;
        step(1);
        sample_en2 = 1'b1;
        wait_cnv(10);
        measure(300, -1, -1, r);
        check("slow_cnv_hi", r.cnv_hi, 4);
        check("slow_sck_pulses", r.sck_pulses, 16);
        check("slow_sck_hi", r.sck_hi, 48);
        check("slow_valid_at", r.valid_at, 125);
        check("slow_period", r.period, 126);
        check("slow_data", r.data, 64'h2468_1357_0FF0_C001);
        sample_en2 = 1'b0;
        wait_idle(300);
        sel = 1'b0;

        // reset in the middle of SHIFT bit 7 with a word pending
        m_ready = 1'b0;
        set_pat(16'h1357, 16'h2468, 16'h369C, 16'h48B0);
        step(1);
        sample_en = 1'b1;
        wait_cnv(10);
        step(61);
        check("rstmid_pre_valid", m_valid, 1);
        wait_cnv(10);
        set_pat(16'hFACE, 16'hCAFE, 16'hBEAD, 16'hF00D);
        step(43);
        check("rstmid_bit7_sck", sck, 1);
        rst = 1'b1;
        #1;
        check("rstmid_cnv", cnv, 0);
        check("rstmid_sck", sck, 0);
        check("rstmid_valid", m_valid, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_data", m_data, 0);
        step(2);
        m_ready = 1'b1;
        rst = 1'b0;
        wait_cnv(10);
        measure(200, -1, -1, r);
        check("rstmid_after_valid_at", r.valid_at, 61);
        check("rstmid_after_data", r.data, 64'hF00D_BEAD_CAFE_FACE);
        check("rstmid_after_period", r.period, 64);
        sample_en = 1'b0;
        wait_idle(200);

        // sample_en dropped two cycles into CNVH
        set_pat(16'h0F1E, 16'h2D3C, 16'h4B5A, 16'h6978);
        step(1);
        sample_en = 1'b1;
        step(1);
        measure(150, 1, -1, r);
        check("drop_cnv_hi", r.cnv_hi, 4);
        check("drop_valid_at", r.valid_at, 61);
        check("drop_data", r.data, 64'h6978_4B5A_2D3C_0F1E);
        check("drop_second_cnv", r.period, -1);
        check("drop_last_busy", r.last_busy, 63);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_multilane_capture.md
Name: adc_multilane_capture

Overview:
- Parametrised successor to the fixed 4-lane, 16-bit LTC2324-class capture controller.
- Generates CNV and SCK for a simultaneous-sampling ADC with NUM_LANES serial data lanes.
- Deserialises all lanes in the clk domain. No gated clock and no CLKOUT-domain logic.
- Presents each frame as one wide word on a valid/ready output, with an overrun flag, continuous or single-shot triggering, and a programmable frame period. Feeds the DMA stream packer.

Parameters:
- NUM_LANES, 4, number of SDO lanes/channels captured per frame (1..8).
- DATA_W, 16, bits per lane per conversion, MSB first.
- TCNVH_CYC, 4, CNV high time in clk cycles (>=1).
- TCONV_CYC, 25, conversion wait after CNV falls, in clk cycles (>=1).
- SCK_HALF, 1, SCK half-period in clk cycles (>=1).
- FRAME_CYC, 64, target frame period in clk cycles, measured from CNV rise to the next CNV rise.
- CNT_W, 8, width of internal timing counters. Must hold max(FRAME_CYC, TCONV_CYC, 2*SCK_HALF*DATA_W).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- sample_en  in  1  level: run continuous conversions while high
- trigger  in  1  single-cycle pulse: run exactly one frame from IDLE
- overrun_clr  in  1  single-cycle pulse: clear the overrun flag
- cnv  out  1  ADC convert start, registered
- sck  out  1  ADC serial clock, registered, low when idle
- sdo  in  NUM_LANES  ADC serial data. Lane i on sdo[i]. Synchronised externally.
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accept
- m_data  out  NUM_LANES*DATA_W  lane i in m_data[i*DATA_W +: DATA_W]
- overrun  out  1  sticky: a completed frame was dropped
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst high, async): state IDLE; cnv=0, sck=0, m_valid=0, m_data=0, overrun=0, busy=0; all counters and the shift registers cleared. Reset asserted mid-frame aborts the frame immediately, with no partial output.
- States: IDLE, CNVH, CONV, SHIFT, WAIT. A frame counter fcnt resets to 0 on CNVH entry and increments every cycle of the frame.
- IDLE: go to CNVH if sample_en=1 or trigger=1. If both are high, treat the frame as continuous.
- CNVH: cnv=1 for exactly TCNVH_CYC cycles, then go to CONV.
- CONV: cnv=0 for TCONV_CYC cycles, then go to SHIFT.
- SHIFT: DATA_W SCK periods, total 2*SCK_HALF*DATA_W cycles.
  - sck rises on SHIFT entry.
  - Each bit: sck high SCK_HALF cycles, then low SCK_HALF cycles.
  - On the last clk cycle of each high phase, shift sdo[i] into lane i's shift register LSB; the first bit captured is the MSB.
  - After the last bit's low phase, go to WAIT. sck is 0 in every other state.
- Frame load: on the WAIT entry cycle, if m_valid=0 or m_ready=1, load m_data from the shift registers and set m_valid=1. Otherwise keep m_data unchanged, drop the frame, and set overrun=1.
  - Latency: m_valid rises TCNVH_CYC+TCONV_CYC+2*SCK_HALF*DATA_W cycles after CNV rises (61 with defaults).
- WAIT:
  - Minimum 1 cycle.
  - Exit when fcnt reaches FRAME_CYC-1, or after 1 cycle if FRAME_CYC is already exceeded. The effective period is max(FRAME_CYC, TCNVH_CYC+TCONV_CYC+2*SCK_HALF*DATA_W+1).
  - On exit: if sample_en=1, go to CNVH; else go to IDLE.
  - A trigger pulse outside IDLE is ignored.
- sample_en falling mid-frame: the frame completes fully (CNV is never truncated), then the block returns to IDLE.
- Output handshake: m_valid stays high and m_data stays stable until m_valid&&m_ready; m_valid then drops the next cycle unless a load happens in that same cycle. Simultaneous accept and load: the new word replaces the old one, m_valid stays 1, no overrun.
- overrun:
  - Sticky; cleared only by overrun_clr or rst.
  - If overrun_clr and a new drop coincide, overrun stays 1.
  - overrun never alters m_data.

Test Plan:
- Defaults, sample_en=1, m_ready=1, sdo[i] driven from per-lane patterns 0x1234, 0xA5A5, 0x0001, 0xFFFF -> cnv high 4 cycles; 16 sck pulses, each 1 high + 1 low; m_valid pulses 61 cycles after cnv rise; m_data={0xFFFF,0x0001,0xA5A5,0x1234}; next cnv rise exactly 64 cycles after the previous one.
- trigger pulse with sample_en=0 -> exactly one frame, one m_valid, busy drops after WAIT, no second cnv; a trigger issued mid-frame produces no extra frame.
- m_ready=0 for 3 consecutive frames, then 1 -> first word is held unchanged; overrun=1 after frame 2; overrun_clr pulse clears it; the held word is still the frame-1 data.
- SCK_HALF=3, FRAME_CYC=10 (shorter than needed) -> sck high 3 / low 3; period = 4+25+96+1 = 126 cycles.
- rst asserted during SHIFT bit 7 -> cnv, sck, m_valid, busy immediately 0; after release with sample_en=1, the first frame is complete and correct, with no partial data.
- sample_en dropped 2 cycles into CNVH -> cnv still held 4 cycles, frame completes with valid data, block returns to IDLE.
